// File: rtl/dev_timer_if.sv
// Bus slot seen by dev_timer: strobe/ack handshake, slot-local address,
// direction, write data and registered read data.
interface dev_timer_if #(
    parameter int MASK_LEN = 10
);
    logic                i_stb;
    logic                o_ack;
    logic [MASK_LEN-1:0] i_addr;
    logic                i_rw;
    logic [31:0]         i_dtw;
    logic [31:0]         o_dtr;

    modport master (
        output i_stb, i_addr, i_rw, i_dtw,
        input  o_ack, o_dtr
    );

    modport slave (
        input  i_stb, i_addr, i_rw, i_dtw,
        output o_ack, o_dtr
    );
endinterface

// File: rtl/dev_timer.sv
// dev_timer: 32-bit timer/compare peripheral on one interconnect slot.
// Prescaled free-running counter, compare match with optional auto-clear,
// overflow flag, W1C status and a registered level interrupt.
module dev_timer #(
    parameter int          MASK_LEN      = 10,
    parameter int          PRESCALE_W    = 8,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       reset,
    dev_timer_if.slave bus,
    output logic       o_irq
);

    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_start;

    logic                  r_en;
    logic                  r_autoclr;
    logic                  r_irqen;
    logic [PRESCALE_W-1:0] r_pre_div;
    logic [PRESCALE_W-1:0] r_prescaler;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic [1:0]            r_status;
    logic [31:0]           r_dtr;
    logic                  r_irq;

    logic [1:0]            w_sel;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_count;
    logic                  w_wr_compare;
    logic                  w_wr_status;
    logic                  w_pre_hit;
    logic                  w_tick;
    logic                  w_eq;
    logic                  w_set_match;
    logic                  w_set_ovf;
    logic [31:0]           w_ctrl_rd;
    logic [31:0]           w_rd_data;
    logic                  w_unused_addr;

    // Only addr[3:2] select a register; the rest of the slot address is ignored.
    assign w_unused_addr = ^{bus.i_addr[MASK_LEN-1:4], bus.i_addr[1:0]};
    assign w_sel         = bus.i_addr[3:2];

    assign w_wr         = w_start & bus.i_rw;
    assign w_wr_ctrl    = w_wr & (w_sel == 2'd0);
    assign w_wr_count   = w_wr & (w_sel == 2'd1);
    assign w_wr_compare = w_wr & (w_sel == 2'd2);
    assign w_wr_status  = w_wr & (w_sel == 2'd3);

    // A CTRL write restarts the prescaler and swallows any tick on that edge.
    assign w_pre_hit = (r_prescaler == r_pre_div);
    assign w_tick    = r_en & w_pre_hit & ~w_wr_ctrl;

    // A bus write to COUNT overrides the tick, including its flag side effects.
    assign w_eq        = (r_count == r_compare);
    assign w_set_match = w_tick & ~w_wr_count & w_eq;
    assign w_set_ovf   = w_tick & ~w_wr_count & ~w_eq & (r_count == 32'hFFFF_FFFF);

    assign w_ctrl_rd = {{(24 - PRESCALE_W){1'b0}}, r_pre_div, 5'd0, r_irqen, r_autoclr, r_en};

    // Read mux: pre-write value of the addressed register.
    always_comb begin
        w_rd_data = 32'd0;
        case (w_sel)
            2'd0:    w_rd_data = w_ctrl_rd;
            2'd1:    w_rd_data = r_count;
            2'd2:    w_rd_data = r_compare;
            default: w_rd_data = {30'd0, r_status};
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Bus FSM next state: one ACK cycle per accepted strobe.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_stb) w_state_nxt = S_ACK;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus FSM outputs: ack straight from state so reset drops it at once.
    always_comb begin
        bus.o_ack = (r_state == S_ACK);
        w_start   = (r_state == S_IDLE) & bus.i_stb;
    end

    // Read data is captured on the accepting edge and held until the next transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_dtr <= 32'd0;
        else if (w_start) r_dtr <= w_rd_data;
    end

    assign bus.o_dtr = r_dtr;

    // CTRL and COMPARE registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en      <= 1'b0;
            r_autoclr <= 1'b0;
            r_irqen   <= 1'b0;
            r_pre_div <= '0;
            r_compare <= RESET_COMPARE;
        end else begin
            if (w_wr_ctrl) begin
                r_en      <= bus.i_dtw[0];
                r_autoclr <= bus.i_dtw[1];
                r_irqen   <= bus.i_dtw[2];
                r_pre_div <= bus.i_dtw[8 +: PRESCALE_W];
            end
            if (w_wr_compare) r_compare <= bus.i_dtw;
        end
    end

    // Prescaler: counts 0..PRE while enabled, held at 0 otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             r_prescaler <= '0;
        else if (!r_en || w_wr_ctrl || w_pre_hit) r_prescaler <= '0;
        else                                    r_prescaler <= r_prescaler + 1'b1;
    end

    // Counter: bus write wins; on tick either auto-clear on match or increment
    // (the all-ones case wraps to zero through the modulo add).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      r_count <= 32'd0;
        else if (w_wr_count)             r_count <= bus.i_dtw;
        else if (w_tick) begin
            if (w_eq && r_autoclr)       r_count <= 32'd0;
            else                         r_count <= r_count + 32'd1;
        end
    end

    // Status flags: W1C clear first, then hardware set so a same-edge set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_status <= 2'b00;
        end else begin
            r_status <= (r_status & ~(w_wr_status ? bus.i_dtw[1:0] : 2'b00))
                      | {w_set_ovf, w_set_match};
        end
    end

    // Interrupt line registered from the flags and IRQEN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_irq <= 1'b0;
        else        r_irq <= r_irqen & (|r_status);
    end

    assign o_irq = r_irq;

endmodule

// File: tb/tb_dev_timer.sv
// Bench for dev_timer: directed scenarios with literal expectations plus a
// randomized bus sequence checked every cycle against a behavioural model.
module tb_dev_timer;

    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

    logic clk;
    logic reset;
    logic irq;

    int n_chk;
    int n_fail;

    dev_timer_if #(.MASK_LEN(10)) bus ();

    dev_timer #(
        .MASK_LEN     (10),
        .PRESCALE_W   (8),
        .RESET_COMPARE(32'hFFFF_FFFF)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .o_irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view of the peripheral.
    typedef struct packed {
        logic        ack;
        logic [31:0] dtr;
        logic        irq;
        logic [31:0] ctrl;
        logic [31:0] count;
        logic [31:0] cmp;
        logic [1:0]  st;
        logic [7:0]  div;
    } mst_t;

    localparam mst_t M_RST = '{ack: 1'b0, dtr: 32'd0, irq: 1'b0, ctrl: 32'd0,
                               count: 32'd0, cmp: 32'hFFFF_FFFF, st: 2'b00, div: 8'd0};

    mst_t m;

    function automatic mst_t model_next(mst_t s, logic stb, logic rw,
                                        logic [9:0] addr, logic [31:0] d);
        mst_t        n;
        logic        start;
        logic        wr;
        logic [1:0]  sel;
        logic        tick;
        logic [1:0]  set;
        logic [1:0]  clr;
        n     = s;
        set   = 2'b00;
        clr   = 2'b00;
        sel   = addr[3:2];
        start = !s.ack && stb;
        wr    = start && rw;
        n.ack = start;
        if (start) begin
            case (sel)
                2'd0:    n.dtr = s.ctrl;
                2'd1:    n.dtr = s.count;
                2'd2:    n.dtr = s.cmp;
                default: n.dtr = {30'd0, s.st};
            endcase
        end
        tick  = s.ctrl[0] && !(wr && sel == 2'd0) && (s.div == s.ctrl[15:8]);
        n.div = (!s.ctrl[0] || (wr && sel == 2'd0) || s.div == s.ctrl[15:8]) ? 8'd0 : s.div + 8'd1;
        if (wr && sel == 2'd1) begin
            n.count = d;
        end else if (tick) begin
            if (s.count == s.cmp) begin
                set[0]  = 1'b1;
                n.count = s.ctrl[1] ? 32'd0 : s.count + 32'd1;
            end else if (s.count == 32'hFFFF_FFFF) begin
                set[1]  = 1'b1;
                n.count = 32'd0;
            end else begin
                n.count = s.count + 32'd1;
            end
        end
        if (wr && sel == 2'd0) n.ctrl = d & CTRL_MASK;
        if (wr && sel == 2'd2) n.cmp = d;
        if (wr && sel == 2'd3) clr = d[1:0];
        n.st  = (s.st & ~clr) | set;
        n.irq = s.ctrl[2] && (s.st != 2'b00);
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= M_RST;
        else        m <= model_next(m, bus.i_stb, bus.i_rw, bus.i_addr, bus.i_dtw);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic xfer(input logic rw, input logic [1:0] sel, input logic [31:0] d,
                        output logic [31:0] q);
        logic [9:0] a;
        a       = 10'($urandom);
        a[3:2]  = sel;
        @(negedge clk);
        bus.i_stb  = 1'b1;
        bus.i_rw   = rw;
        bus.i_addr = a;
        bus.i_dtw  = d;
        @(negedge clk);
        chk("ack_latency", {31'd0, bus.o_ack}, 32'd1);
        q          = bus.o_dtr;
        bus.i_stb  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        logic [31:0] q;
        xfer(1'b1, sel, d, q);
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] q);
        xfer(1'b0, sel, 32'd0, q);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] d;
        logic [1:0]  sel;
        n_chk      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        bus.i_stb  = 1'b0;
        bus.i_rw   = 1'b0;
        bus.i_addr = '0;
        bus.i_dtw  = '0;

        fork
            forever begin
                @(negedge clk);
                chk("cyc_ack", {31'd0, bus.o_ack}, {31'd0, m.ack});
                chk("cyc_irq", {31'd0, irq}, {31'd0, m.irq});
                chk("cyc_dtr", bus.o_dtr, m.dtr);
            end
        join_none

        #23;
        chk("rst_ack", {31'd0, bus.o_ack}, 32'd0);
        chk("rst_dtr", bus.o_dtr, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;

        // Dirty the registers, then reset in the middle of an ACK.
        wr(2'd2, 32'h0000_0003);
        wr(2'd1, 32'h0000_1234);
        wr(2'd0, 32'h0000_0007);
        @(negedge clk);
        bus.i_stb  = 1'b1;
        bus.i_rw   = 1'b0;
        bus.i_addr = 10'h004;
        @(posedge clk);
        #2;
        chk("ack_before_rst", {31'd0, bus.o_ack}, 32'd1);
        reset = 1'b0;
        #1;
        chk("ack_async_rst", {31'd0, bus.o_ack}, 32'd0);
        bus.i_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        rd(2'd1, q); chk("rst_count", q, 32'd0);
        rd(2'd2, q); chk("rst_compare", q, 32'hFFFF_FFFF);
        rd(2'd0, q); chk("rst_ctrl", q, 32'd0);
        rd(2'd3, q); chk("rst_status", q, 32'd0);

        // Basic write/read of CTRL, then back-to-back strobes.
        wr(2'd0, 32'h0000_0001);
        rd(2'd0, q); chk("ctrl_readback", q, 32'h0000_0001);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, q); chk("ctrl_mask", q, 32'h0000_FF07);
        wr(2'd0, 32'd0);
        @(negedge clk);
        bus.i_stb  = 1'b1;
        bus.i_rw   = 1'b0;
        bus.i_addr = 10'h000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_ack", {31'd0, bus.o_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        bus.i_stb = 1'b0;

        // Prescale PRE=3: ticks every 4th edge after the CTRL write.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h0000_0301);
        repeat (3) @(negedge clk);
        rd(2'd1, q); chk("pre3_count1", q, 32'd1);
        repeat (14) @(negedge clk);
        rd(2'd1, q); chk("pre3_count5", q, 32'd5);

        // PRE=0: one increment per cycle.
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h0000_0001);
        rd(2'd1, q); chk("pre0_count_a", q, 32'd1);
        rd(2'd1, q); chk("pre0_count_b", q, 32'd3);

        // Match with auto-clear and interrupt, then W1C.
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd3);
        wr(2'd2, 32'd5);
        wr(2'd0, 32'h0000_0007);
        repeat (6) @(negedge clk);
        chk("match_irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("match_irq", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h0000_0004);
        rd(2'd1, q); chk("autoclr_count", q, 32'd2);
        rd(2'd3, q); chk("match_status", q, 32'd1);
        wr(2'd3, 32'd1);
        @(negedge clk);
        chk("w1c_irq", {31'd0, irq}, 32'd0);

        // Overflow without a compare match.
        wr(2'd0, 32'd0);
        wr(2'd3, 32'd3);
        wr(2'd1, 32'hFFFF_FFFE);
        wr(2'd2, 32'h0000_0010);
        wr(2'd0, 32'h0000_0005);
        @(negedge clk);
        chk("ovf_irq_pre", {31'd0, irq}, 32'd0);
        rd(2'd1, q); chk("ovf_count", q, 32'd0);
        chk("ovf_irq", {31'd0, irq}, 32'd1);
        rd(2'd3, q); chk("ovf_status", q, 32'd2);

        // COUNT write on the matching tick edge.
        wr(2'd0, 32'd0);
        wr(2'd3, 32'd3);
        wr(2'd2, 32'h0000_0050);
        wr(2'd1, 32'h0000_0050);
        wr(2'd0, 32'h0000_0101);
        wr(2'd1, 32'h0000_0100);
        wr(2'd0, 32'd0);
        rd(2'd1, q); chk("coll_count", q, 32'h0000_0100);
        rd(2'd3, q); chk("coll_status", q, 32'd0);

        // W1C on the edge that sets MATCH.
        wr(2'd1, 32'h0000_0050);
        wr(2'd0, 32'h0000_0101);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'd0);
        rd(2'd3, q); chk("w1c_coll_status", q, 32'd1);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int t = 0; t < 400; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sel = 2'($urandom);
            case (sel)
                2'd0: begin
                    d = $urandom;
                    d[15:8] = 8'($urandom_range(0, 3));
                end
                2'd1: begin
                    case ($urandom_range(0, 2))
                        0:       d = 32'($urandom_range(0, 20));
                        1:       d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                        default: d = $urandom;
                    endcase
                end
                2'd2:    d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 20));
                default: d = $urandom;
            endcase
            xfer(($urandom_range(0, 2) != 0), sel, d, q);
        end
        for (int r = 0; r < 4; r++) rd(2'(r), q);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
